// File: rtl/sevenseg_pkg.sv
// rtl/sevenseg_pkg.sv - seven-segment glyph and code constants
package sevenseg_pkg;

    // Segment order {g,f,e,d,c,b,a}, active-low.
    localparam logic [6:0] SEG_BLANK  = 7'h7F;
    localparam logic [6:0] SEG_DASH   = 7'h3F;
    localparam logic [3:0] CODE_BLANK = 4'hF;

    localparam logic [6:0] SEG_0 = 7'h40;
    localparam logic [6:0] SEG_1 = 7'h79;
    localparam logic [6:0] SEG_2 = 7'h24;
    localparam logic [6:0] SEG_3 = 7'h30;
    localparam logic [6:0] SEG_4 = 7'h19;
    localparam logic [6:0] SEG_5 = 7'h12;
    localparam logic [6:0] SEG_6 = 7'h02;
    localparam logic [6:0] SEG_7 = 7'h78;
    localparam logic [6:0] SEG_8 = 7'h00;
    localparam logic [6:0] SEG_9 = 7'h10;

endpackage

// File: rtl/sevenseg_decode.sv
// rtl/sevenseg_decode.sv - 4-bit digit code to active-low seven-segment pattern
module sevenseg_decode
    import sevenseg_pkg::*;
(
    input  logic [3:0] code,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_DASH;
        case (code)
            4'd0:       seg = SEG_0;
            4'd1:       seg = SEG_1;
            4'd2:       seg = SEG_2;
            4'd3:       seg = SEG_3;
            4'd4:       seg = SEG_4;
            4'd5:       seg = SEG_5;
            4'd6:       seg = SEG_6;
            4'd7:       seg = SEG_7;
            4'd8:       seg = SEG_8;
            4'd9:       seg = SEG_9;
            CODE_BLANK: seg = SEG_BLANK;
            default:    seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/sevenseg4_scan.sv
// rtl/sevenseg4_scan.sv - 4-digit multiplexed display scanner with frame-aligned updates
module sevenseg4_scan
    import sevenseg_pkg::*;
#(
    parameter int DIV   = 1000,
    parameter int BLANK = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic [3:0] C,
    input  logic [3:0] D,
    input  logic       update,
    input  logic       lzb_en,
    input  logic [3:0] dp,
    output logic [6:0] seg,
    output logic       dp_n,
    output logic [3:0] an,
    output logic       frame
);

    localparam logic [15:0] PC_LAST  = 16'(DIV - 1);
    localparam logic [15:0] PC_BLANK = 16'(BLANK);

    logic [15:0] pc;
    logic [1:0]  idx;
    logic [15:0] stage;
    logic [15:0] shadow;
    logic        pend;
    logic        frame_d;

    logic        tick;
    logic        boundary;
    logic        dead;
    logic [3:0]  cur_code;
    logic [6:0]  cur_seg;
    logic [3:0]  lz_blank;

    assign tick     = (pc == PC_LAST);
    assign boundary = tick && (idx == 2'd3);
    assign dead     = (pc < PC_BLANK);
    assign cur_code = shadow[{idx, 2'b00} +: 4];

    // A zero digit is blanked only while everything to its left is zero or already blank.
    function automatic logic zero_or_blank(input logic [3:0] code);
        return (code == 4'd0) || (code == CODE_BLANK);
    endfunction

    always_comb begin
        lz_blank    = 4'b0000;
        lz_blank[3] = (shadow[15:12] == 4'd0);
        lz_blank[2] = (shadow[11:8] == 4'd0) && zero_or_blank(shadow[15:12]);
        lz_blank[1] = (shadow[7:4] == 4'd0) && zero_or_blank(shadow[11:8])
                      && zero_or_blank(shadow[15:12]);
    end

    sevenseg_decode u_decode (
        .code (cur_code),
        .seg  (cur_seg)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            pc      <= '0;
            idx     <= '0;
            stage   <= {4{CODE_BLANK}};
            shadow  <= {4{CODE_BLANK}};
            pend    <= 1'b0;
            frame_d <= 1'b0;
            frame   <= 1'b0;
            an      <= 4'hF;
            seg     <= SEG_BLANK;
            dp_n    <= 1'b1;
        end else begin
            pc <= tick ? '0 : pc + 16'd1;
            if (tick) begin
                idx <= idx + 2'd1;
            end

            if (update) begin
                stage <= {D, C, B, A};
                pend  <= 1'b1;
            end
            if (boundary) begin
                if (update) begin
                    shadow <= {D, C, B, A};
                    pend   <= 1'b0;
                end else if (pend) begin
                    shadow <= stage;
                    pend   <= 1'b0;
                end
            end

            // Two-stage so the pulse lands on the first slot-0 dead-time output cycle.
            frame_d <= boundary;
            frame   <= frame_d;

            an   <= dead ? 4'hF : ~(4'b0001 << idx);
            seg  <= (lzb_en && lz_blank[idx]) ? SEG_BLANK : cur_seg;
            dp_n <= dead ? 1'b1 : ~dp[idx];
        end
    end

endmodule

// File: tb/tb_sevenseg4_scan.sv
// tb/tb_sevenseg4_scan.sv - directed self-checking bench for sevenseg4_scan (DIV=8, BLANK=2)
module tb_sevenseg4_scan;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] A, B, C, D;
    logic       update;
    logic       lzb_en;
    logic [3:0] dp;
    logic [6:0] seg;
    logic       dp_n;
    logic [3:0] an;
    logic       frame;

    int checks = 0;
    int errors = 0;
    int k = 0;

    sevenseg4_scan #(.DIV(8), .BLANK(2)) dut (
        .clk    (clk),
        .rst    (rst),
        .A      (A),
        .B      (B),
        .C      (C),
        .D      (D),
        .update (update),
        .lzb_en (lzb_en),
        .dp     (dp),
        .seg    (seg),
        .dp_n   (dp_n),
        .an     (an),
        .frame  (frame)
    );

    always #5 clk = ~clk;

    // k counts rising edges since reset release; outputs after edge k reflect state of cycle k-1.
    task automatic tick();
        @(posedge clk);
        k++;
        @(negedge clk);
    endtask

    task automatic run_to(input int target);
        while (k < target) tick();
    endtask

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s at k=%0d: observed %h expected %h", tag, k, got, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        update = 1'b0;
        @(posedge clk);
        @(negedge clk);
        k = 0;
        chk("rst_an", {4'h0, an}, 8'h0F);
        chk("rst_seg", {1'b0, seg}, 8'h7F);
        chk("rst_dp_n", {7'h0, dp_n}, 8'h01);
        chk("rst_frame", {7'h0, frame}, 8'h00);
        rst = 1'b0;
    endtask

    task automatic pulse_update(input int j, input logic [3:0] d, input logic [3:0] c,
                                input logic [3:0] b, input logic [3:0] a);
        run_to(j);
        D = d; C = c; B = b; A = a;
        update = 1'b1;
        tick();
        update = 1'b0;
    endtask

    task automatic check_at(input int target, input logic [3:0] exp_an,
                            input logic [6:0] exp_seg, input string tag);
        run_to(target);
        chk({tag, "_an"}, {4'h0, an}, {4'h0, exp_an});
        chk({tag, "_seg"}, {1'b0, seg}, {1'b0, exp_seg});
    endtask

    // Blank display free run: scan pattern, 2-cycle gaps, frame every 32 cycles.
    task automatic free_run(input int n, input string tag);
        logic [3:0] one;
        logic [3:0] exp_an;
        int p, i;
        one = 4'b0001;
        for (int s = 0; s < n; s++) begin
            tick();
            p = (k - 1) % 8;
            i = ((k - 1) / 8) % 4;
            exp_an = (p < 2) ? 4'hF : ~(one << i);
            chk({tag, "_an"}, {4'h0, an}, {4'h0, exp_an});
            chk({tag, "_seg"}, {1'b0, seg}, 8'h7F);
            chk({tag, "_dp_n"}, {7'h0, dp_n}, 8'h01);
            chk({tag, "_frame"}, {7'h0, frame}, {7'h0, (k >= 33) && (k % 32 == 1)});
        end
    endtask

    initial begin
        rst = 1'b1; update = 1'b0; lzb_en = 1'b0; dp = 4'b0000;
        A = 4'h0; B = 4'h0; C = 4'h0; D = 4'h0;
        @(posedge clk);
        @(negedge clk);
        do_reset();

        free_run(70, "free");

        // Mid-frame update is held until the boundary at cycle 95.
        pulse_update(72, 4'd1, 4'd2, 4'd3, 4'd4);
        check_at(75, 4'b1101, 7'h7F, "hold_p1");
        check_at(91, 4'b0111, 7'h7F, "hold_p3");
        run_to(97);
        chk("apply_frame", {7'h0, frame}, 8'h01);
        chk("apply_dead_an", {4'h0, an}, 8'h0F);
        check_at(99, 4'b1110, 7'h19, "show4");
        check_at(107, 4'b1101, 7'h30, "show3");
        check_at(115, 4'b1011, 7'h24, "show2");
        check_at(123, 4'b0111, 7'h79, "show1");

        // Leading-zero blanking of 0070.
        lzb_en = 1'b1;
        pulse_update(130, 4'd0, 4'd0, 4'd7, 4'd0);
        check_at(163, 4'b1110, 7'h40, "lzb_p0");
        check_at(171, 4'b1101, 7'h78, "lzb_p1");
        check_at(179, 4'b1011, 7'h7F, "lzb_p2");
        check_at(187, 4'b0111, 7'h7F, "lzb_p3");
        lzb_en = 1'b0;
        check_at(195, 4'b1110, 7'h40, "nolzb_p0");
        check_at(211, 4'b1011, 7'h40, "nolzb_p2");

        // Update on the boundary cycle applies at once; a later one waits a full frame.
        pulse_update(223, 4'd9, 4'd9, 4'd9, 4'd9);
        pulse_update(226, 4'd0, 4'd0, 4'd0, 4'd0);
        check_at(227, 4'b1110, 7'h10, "b9_p0");
        check_at(251, 4'b0111, 7'h10, "b9_p3");
        run_to(257);
        chk("b0_frame", {7'h0, frame}, 8'h01);
        check_at(259, 4'b1110, 7'h40, "b0_p0");
        check_at(283, 4'b0111, 7'h40, "b0_p3");

        // Decimal point on position 2 and dash glyph on position 0.
        dp = 4'b0100;
        pulse_update(284, 4'd4, 4'd5, 4'd6, 4'hB);
        check_at(291, 4'b1110, 7'h3F, "dash_p0");
        chk("dp_p0", {7'h0, dp_n}, 8'h01);
        check_at(299, 4'b1101, 7'h02, "dp_p1");
        chk("dp_p1_n", {7'h0, dp_n}, 8'h01);
        check_at(305, 4'b1111, 7'h12, "dp_dead0");
        chk("dp_dead0_n", {7'h0, dp_n}, 8'h01);
        check_at(306, 4'b1111, 7'h12, "dp_dead1");
        chk("dp_dead1_n", {7'h0, dp_n}, 8'h01);
        check_at(307, 4'b1011, 7'h12, "dp_p2a");
        chk("dp_p2a_n", {7'h0, dp_n}, 8'h00);
        check_at(312, 4'b1011, 7'h12, "dp_p2b");
        chk("dp_p2b_n", {7'h0, dp_n}, 8'h00);
        check_at(313, 4'b1111, 7'h19, "dp_dead3");
        chk("dp_dead3_n", {7'h0, dp_n}, 8'h01);
        check_at(315, 4'b0111, 7'h19, "dp_p3");
        chk("dp_p3_n", {7'h0, dp_n}, 8'h01);
        dp = 4'b0000;

        // Reset with an update pending: the pending 8888 must never appear.
        pulse_update(320, 4'd8, 4'd8, 4'd8, 4'd8);
        run_to(325);
        do_reset();
        free_run(80, "postrst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
